// File: rtl/serial_subtract_ctrl.sv
// Bit-serial subtractor controller: sequences an external single-bit
// full-subtractor cell LSB-first and assembles the parallel difference.
module serial_subtract_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_borrow_in,
  output logic             cell_start,
  input  logic             cell_diff,
  input  logic             cell_borrow_out,
  input  logic             cell_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic [WIDTH-1:0] w_res_next;

  // Result shift register with the new cell bit entering at the MSB
  // (written as shift/or so that WIDTH=1 needs no special case).
  always_comb begin
    w_res_next = (r_res_sr >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_res_sr     <= '0;
      r_brw        <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op_start) begin
            r_a_sr   <= op_a;
            r_b_sr   <= op_b;
            r_brw    <= op_borrow_in;
            r_cnt    <= '0;
            r_res_sr <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (cell_done) begin
            r_res_sr <= w_res_next;
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_brw    <= cell_borrow_out;
            if (r_cnt == LAST_BIT) begin
              // Counter parks on the last bit so it never exceeds WIDTH-1.
              r_diff       <= w_res_next;
              r_borrow_out <= cell_borrow_out;
              r_state      <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and cell-drive outputs decoded from registered state.
  always_comb begin
    busy           = (r_state == S_RUN) || (r_state == S_DONE);
    done           = (r_state == S_DONE);
    cell_start     = (r_state == S_RUN);
    cell_a         = r_a_sr[0];
    cell_b         = r_b_sr[0];
    cell_borrow_in = r_brw;
    diff           = r_diff;
    borrow_out     = r_borrow_out;
  end

endmodule
